// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier, one digit per clock.
// Signed/unsigned operands, valid/ready on both sides.
module booth_radix4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int AW = 2 * WIDTH + 4;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        r_state;
    logic [E-1:0]  r_m;
    logic [E:0]    r_q;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;

    logic          w_ext_a;
    logic          w_ext_b;
    logic [AW-1:0] w_m_sx;
    logic [AW-1:0] w_m2_sx;
    logic [AW-1:0] w_term;
    logic [AW-1:0] w_acc_next;
    logic [E:0]    w_q_shr;

    assign w_ext_a = signed_mode & a[WIDTH-1];
    assign w_ext_b = signed_mode & b[WIDTH-1];

    // Two extension bits keep unsigned operands positive under Booth recoding
    assign w_m_sx  = {{(AW-E){r_m[E-1]}}, r_m};
    assign w_m2_sx = w_m_sx << 1;

    always_comb begin
        w_term = '0;
        case (r_q[2:0])
            3'b001, 3'b010: w_term = w_m_sx;
            3'b011:         w_term = w_m2_sx;
            3'b100:         w_term = -w_m2_sx;
            3'b101, 3'b110: w_term = -w_m_sx;
            default:        w_term = '0;
        endcase
    end

    assign w_acc_next = r_acc + (w_term << {r_cnt, 1'b0});
    assign w_q_shr    = $signed(r_q) >>> 2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            p         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_m      <= {{2{w_ext_a}}, a};
                        r_q      <= {{2{w_ext_b}}, b, 1'b0};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_q   <= w_q_shr;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        p         <= w_acc_next[2*WIDTH-1:0];
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Bench for booth_radix4_seq_mult: directed corners, reset
// abort and randomized traffic against an arithmetic model.
module tb_booth_radix4_seq_mult;
    localparam int W   = 8;
    localparam int LAT = W / 2 + 1;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           busy;

    int n_vec;
    int n_err;

    booth_radix4_seq_mult #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .p          (p),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic s);
        longint xv;
        longint yv;
        xv = s ? longint'($signed(x)) : longint'(x);
        yv = s ? longint'($signed(y)) : longint'(y);
        return (2*W)'(xv * yv);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input int hold);
        logic [2*W-1:0] exp;
        int k;
        exp = ref_mul(ta, tb, ts);
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        a = ta;
        b = tb;
        signed_mode = ts;
        in_valid = 1'b1;
        tick();
        check("busy_calc", 32'(busy), 32'd1);
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = 1'($urandom);
        k = 0;
        while (!out_valid && k < 20) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            k++;
        end
        out_ready = 1'b0;
        check("latency", 32'(k), 32'(LAT));
        check("product", 32'(p), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_p", 32'(p), 32'(exp));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drop_valid", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("p_held", 32'(p), 32'(exp));
    endtask

    initial begin
        logic [W-1:0] corners [5];
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

        #3 rst_n = 1'b0;
        #5;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op(8'hFF, 8'hFF, 1'b0, 0);
        check("t1_fe01", 32'(p), 32'h0000_FE01);
        run_op(8'h80, 8'h80, 1'b1, 0);
        check("t2_4000", 32'(p), 32'h0000_4000);
        run_op(8'h80, 8'h7F, 1'b1, 1);
        check("t2_c080", 32'(p), 32'h0000_C080);
        run_op(8'hFF, 8'hFF, 1'b1, 2);
        check("t2_0001", 32'(p), 32'h0000_0001);
        run_op(8'h00, 8'hA5, 1'b1, 0);
        check("zero", 32'(p), 32'h0000_0000);
        run_op(8'h5A, 8'hC3, 1'b0, 10);

        a = 8'd200;
        b = 8'd100;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_p", 32'(p), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_result", 32'(out_valid), 32'd0);
        run_op(8'd3, 8'd5, 1'b0, 0);
        check("after_abort", 32'(p), 32'd15);

        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    run_op(corners[i], corners[j], 1'(m), 0);

        for (int n = 0; n < 4000; n++)
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
